retire_trace_buffer: RTL and testbench
======================================

// Module: retire_trace_buffer
// PURPOSE
//  Consumer end of the core's retirement trace port. Samples one retire record per clock, tags it
//  with a sequence number and buffers it in a DEPTH-entry FIFO. Drains records over a valid/ready
//  stream to a logger or lockstep checker.
//  The core cannot be stalled, so records that arrive while the FIFO is full are dropped, counted
//  and flagged.
// PARAMETERS
//  XLEN   32  data/address width of trace fields
//  DEPTH  16  FIFO entries; power of two, >= 2
// PORTS
//  clk_i           in   1        system clock; all state updates on rising edge
//  rstn_i          in   1        asynchronous, active-low reset
//  en_i            in   1        capture enable; 0 = ignore retire_valid_i
//  flush_i         in   1        synchronous clear of FIFO, flags, counters
//  retire_valid_i  in   1        a retire record is present this cycle
//  ret_pc_i        in   XLEN     retired PC
//  ret_instr_i     in   32       retired instruction
//  ret_reg_addr_i  in   5        destination register (0 = no write)
//  ret_reg_data_i  in   XLEN     destination register data
//  ret_mem_addr_i  in   XLEN     store address
//  ret_mem_data_i  in   XLEN     store data
//  ret_mem_wrt_i   in   1        store performed
//  trc_valid_o     out  1        head record valid
//  trc_ready_i     in   1        sink accepts head record
//  trc_seq_o       out  16       sequence number of head record
//  trc_gap_o       out  1        one or more records were dropped immediately before this one
//  trc_pc_o / trc_instr_o / trc_reg_addr_o / trc_reg_data_o / trc_mem_addr_o / trc_mem_data_o / trc_mem_wrt_o
//                  out  as ret_* head record fields
//  level_o         out  $clog2(DEPTH)+1  current FIFO occupancy
//  overflow_o      out  1        sticky: at least one drop since reset or flush
//  drop_cnt_o      out  16       number of dropped records, saturating
// BEHAVIOUR
//  - Reset (rstn_i=0, async): FIFO empty, read/write pointers, seq, gap, overflow_o, drop_cnt_o are all 0.
//    All outputs read 0.
//  - Retire event: retire_valid_i & en_i at a rising edge.
//  - Sequence counter: seq increments by 1 on every retire event, whether the record is stored or
//    dropped. seq wraps from 0xFFFF to 0. A stored record carries the seq value held before the increment.
//    Dropped records therefore show as holes in trc_seq_o.
//  - pop = trc_valid_o & trc_ready_i.
//  - push = retire event & (level_o < DEPTH | pop). When full, a simultaneous pop frees the slot, so the push succeeds.
//  - drop = retire event & ~push. On a drop:
//    - drop_cnt_o increments, saturating at 0xFFFF.
//    - overflow_o is set.
//    - the pending-gap flag is set.
//  - Pending-gap flag: written into the next pushed record's gap field, then cleared on that push.
//  - Output side is first-word fall-through. trc_valid_o = (level_o != 0). trc_* fields come from the
//    head entry.
//    - A record pushed at edge N is visible on trc_valid_o from cycle N+1 onward.
//    - It can pop at edge N+1 at the earliest.
//    - There is no combinational path from retire inputs to trc_*.
//  - Stability: while trc_valid_o=1 and trc_ready_i=0, every trc_* field holds stable. trc_ready_i may
//    toggle freely. trc_valid_o never drops without a pop, except on flush or reset.
//  - level_o updates every edge: +1 on push only, -1 on pop only, unchanged when both or neither occur.
//  - flush_i=1 at an edge has priority over push/pop in the same cycle. It empties the FIFO and clears
//    seq, the pending-gap flag, overflow_o and drop_cnt_o. The retire event in that cycle is discarded
//    and not counted.
//  - en_i=0: no retire events occur, so seq, drop_cnt_o and the pending-gap flag are frozen. Draining
//    continues normally.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are distinguished by level_o.
//  - Reset asserted mid-stream discards all buffered records immediately. No handshake completes in that cycle.
// TESTING
//  1. Reset, then 3 retire events, trc_ready_i=0 -> level_o=3, head seq=0 pc=first PC. Ready=1 -> seqs 0,1,2
//     pop on consecutive cycles.
//  2. DEPTH=16, ready=0, 20 events -> level_o=16, drop_cnt_o=4, overflow_o=1. Drain 16 with ready=1, then
//     1 more event -> record has seq=20, gap=1.
//  3. Full FIFO, retire event and pop on the same edge -> push accepted, level_o stays 16, drop_cnt_o unchanged.
//  4. 3 records buffered, flush_i=1 coinciding with a retire event and pop -> next cycle level_o=0,
//     trc_valid_o=0, drop_cnt_o=0. Next event gets seq=0.
//  5. Valid high, ready held 0 for 10 cycles while new events push -> trc_* unchanged. Also force
//     drop_cnt_o to 0xFFFF -> further drops leave it at 0xFFFF. seq rolls from 0xFFFF to 0x0000.
//  6. Assert rstn_i low asynchronously mid-transfer -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/retire_trace_buffer.sv
// Retirement trace capture buffer: tags each retired instruction with a sequence number and queues it
// in a first-word-fall-through FIFO drained over valid/ready; overflow drops are counted and flagged.
module retire_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       en_i,
  input  logic                       flush_i,
  input  logic                       retire_valid_i,
  input  logic [XLEN-1:0]            ret_pc_i,
  input  logic [31:0]                ret_instr_i,
  input  logic [4:0]                 ret_reg_addr_i,
  input  logic [XLEN-1:0]            ret_reg_data_i,
  input  logic [XLEN-1:0]            ret_mem_addr_i,
  input  logic [XLEN-1:0]            ret_mem_data_i,
  input  logic                       ret_mem_wrt_i,
  output logic                       trc_valid_o,
  input  logic                       trc_ready_i,
  output logic [15:0]                trc_seq_o,
  output logic                       trc_gap_o,
  output logic [XLEN-1:0]            trc_pc_o,
  output logic [31:0]                trc_instr_o,
  output logic [4:0]                 trc_reg_addr_o,
  output logic [XLEN-1:0]            trc_reg_data_o,
  output logic [XLEN-1:0]            trc_mem_addr_o,
  output logic [XLEN-1:0]            trc_mem_data_o,
  output logic                       trc_mem_wrt_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = 16 + 1 + 4*XLEN + 32 + 5 + 1;

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [15:0]   seq;
  logic          gap_pend;
  logic          overflow;
  logic [15:0]   drop_cnt;

  logic          retire_evt;
  logic          pop;
  logic          push;
  logic          drop;
  logic [RW-1:0] rec_in;
  logic [RW-1:0] head;

  assign retire_evt = retire_valid_i & en_i;
  assign trc_valid_o = (level != '0);
  assign pop  = trc_valid_o & trc_ready_i;
  assign push = retire_evt & ((level < LW'(DEPTH)) | pop);
  assign drop = retire_evt & ~push;

  assign rec_in = {seq, gap_pend, ret_pc_i, ret_instr_i, ret_reg_addr_i, ret_reg_data_i,
                   ret_mem_addr_i, ret_mem_data_i, ret_mem_wrt_i};

  // Storage is not reset; gating the head with valid keeps every output at zero while empty.
  assign head = trc_valid_o ? mem[rd_ptr] : '0;
  assign {trc_seq_o, trc_gap_o, trc_pc_o, trc_instr_o, trc_reg_addr_o, trc_reg_data_o,
          trc_mem_addr_o, trc_mem_data_o, trc_mem_wrt_o} = head;

  assign level_o    = level;
  assign overflow_o = overflow;
  assign drop_cnt_o = drop_cnt;

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem[wr_ptr] <= rec_in;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      seq      <= '0;
      gap_pend <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      seq      <= '0;
      gap_pend <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (retire_evt) begin
        seq <= seq + 16'd1;
      end
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        gap_pend <= 1'b0;
      end
      if (drop) begin
        gap_pend <= 1'b1;
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: capture, drain, overflow, flush, stability, saturation, reset.
module tb_retire_trace_buffer;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        en_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        retire_valid_i = 1'b0;
  logic [31:0] ret_pc_i = '0;
  logic [31:0] ret_instr_i = '0;
  logic [4:0]  ret_reg_addr_i = '0;
  logic [31:0] ret_reg_data_i = '0;
  logic [31:0] ret_mem_addr_i = '0;
  logic [31:0] ret_mem_data_i = '0;
  logic        ret_mem_wrt_i = 1'b0;
  logic        trc_valid_o;
  logic        trc_ready_i = 1'b0;
  logic [15:0] trc_seq_o;
  logic        trc_gap_o;
  logic [31:0] trc_pc_o;
  logic [31:0] trc_instr_o;
  logic [4:0]  trc_reg_addr_o;
  logic [31:0] trc_reg_data_o;
  logic [31:0] trc_mem_addr_o;
  logic [31:0] trc_mem_data_o;
  logic        trc_mem_wrt_o;
  logic [4:0]  level_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;

  int total = 0;
  int bad = 0;

  retire_trace_buffer #(.XLEN(32), .DEPTH(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i), .flush_i(flush_i),
    .retire_valid_i(retire_valid_i), .ret_pc_i(ret_pc_i), .ret_instr_i(ret_instr_i),
    .ret_reg_addr_i(ret_reg_addr_i), .ret_reg_data_i(ret_reg_data_i),
    .ret_mem_addr_i(ret_mem_addr_i), .ret_mem_data_i(ret_mem_data_i), .ret_mem_wrt_i(ret_mem_wrt_i),
    .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i), .trc_seq_o(trc_seq_o), .trc_gap_o(trc_gap_o),
    .trc_pc_o(trc_pc_o), .trc_instr_o(trc_instr_o), .trc_reg_addr_o(trc_reg_addr_o),
    .trc_reg_data_o(trc_reg_data_o), .trc_mem_addr_o(trc_mem_addr_o), .trc_mem_data_o(trc_mem_data_o),
    .trc_mem_wrt_o(trc_mem_wrt_o), .level_o(level_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({trc_valid_o, level_o, trc_seq_o, trc_pc_o, overflow_o, drop_cnt_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b level=%0d seq=%h pc=%h ovf=%b drop=%h want all 0",
               trc_valid_o, level_o, trc_seq_o, trc_pc_o, overflow_o, drop_cnt_o);
    end
    #10;
    rstn_i = 1'b1;
    en_i = 1'b1;
  endtask

  task automatic test_capture_drain();
    trc_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      retire_valid_i = 1'b1;
      ret_pc_i = 32'h100 + 32'(4*i);
      step();
    end
    retire_valid_i = 1'b0;
    total++;
    if (level_o !== 5'd3) begin bad++; $display("FAIL cap_level got %0d want 3", level_o); end
    total++;
    if (trc_seq_o !== 16'd0 || trc_pc_o !== 32'h100) begin
      bad++; $display("FAIL cap_head got seq=%h pc=%h want seq=0 pc=100", trc_seq_o, trc_pc_o);
    end
    trc_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (trc_valid_o !== 1'b1 || trc_seq_o !== 16'(i) || trc_pc_o !== 32'h100 + 32'(4*i)) begin
        bad++;
        $display("FAIL drain_%0d got v=%b seq=%h pc=%h want v=1 seq=%h", i, trc_valid_o, trc_seq_o,
                 trc_pc_o, i);
      end
      step();
    end
    total++;
    if (trc_valid_o !== 1'b0 || level_o !== 5'd0) begin
      bad++; $display("FAIL drain_empty got v=%b level=%0d want 0 0", trc_valid_o, level_o);
    end
    trc_ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    do_flush();
    for (int i = 0; i < 20; i++) begin
      retire_valid_i = 1'b1;
      ret_pc_i = 32'h1000 + 32'(4*i);
      step();
    end
    retire_valid_i = 1'b0;
    total++;
    if (level_o !== 5'd16 || drop_cnt_o !== 16'd4 || overflow_o !== 1'b1) begin
      bad++;
      $display("FAIL ovf_state got level=%0d drop=%0d ovf=%b want 16 4 1", level_o, drop_cnt_o, overflow_o);
    end
    trc_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (trc_seq_o !== 16'(i) || trc_gap_o !== 1'b0 || trc_pc_o !== 32'h1000 + 32'(4*i)) begin
        bad++;
        $display("FAIL ovf_drain_%0d got seq=%h gap=%b pc=%h want seq=%h gap=0", i, trc_seq_o, trc_gap_o,
                 trc_pc_o, i);
      end
      step();
    end
    trc_ready_i = 1'b0;
    retire_valid_i = 1'b1;
    ret_pc_i = 32'hABC;
    step();
    retire_valid_i = 1'b0;
    total++;
    if (trc_valid_o !== 1'b1 || trc_seq_o !== 16'd20 || trc_gap_o !== 1'b1 || trc_pc_o !== 32'hABC) begin
      bad++;
      $display("FAIL gap_rec got v=%b seq=%0d gap=%b pc=%h want 1 20 1 abc", trc_valid_o, trc_seq_o,
               trc_gap_o, trc_pc_o);
    end
    total++;
    if (drop_cnt_o !== 16'd4 || overflow_o !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky got drop=%0d ovf=%b want 4 1", drop_cnt_o, overflow_o);
    end
    trc_ready_i = 1'b1;
    step();
    trc_ready_i = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_flush();
    for (int i = 0; i < 16; i++) begin
      retire_valid_i = 1'b1;
      ret_pc_i = 32'h2000 + 32'(i);
      step();
    end
    ret_pc_i = 32'h5000;
    trc_ready_i = 1'b1;
    step();
    trc_ready_i = 1'b0;
    total++;
    if (level_o !== 5'd16 || drop_cnt_o !== 16'd0 || trc_seq_o !== 16'd1) begin
      bad++;
      $display("FAIL full_pushpop got level=%0d drop=%0d seq=%0d want 16 0 1", level_o, drop_cnt_o, trc_seq_o);
    end
    ret_pc_i = 32'h6000;
    step();
    retire_valid_i = 1'b0;
    total++;
    if (level_o !== 5'd16 || drop_cnt_o !== 16'd1) begin
      bad++; $display("FAIL full_drop got level=%0d drop=%0d want 16 1", level_o, drop_cnt_o);
    end
    trc_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        total++;
        if (trc_seq_o !== 16'd16 || trc_pc_o !== 32'h5000 || trc_gap_o !== 1'b0) begin
          bad++;
          $display("FAIL full_last got seq=%0d pc=%h gap=%b want 16 5000 0", trc_seq_o, trc_pc_o, trc_gap_o);
        end
      end
      step();
    end
    trc_ready_i = 1'b0;
    total++;
    if (level_o !== 5'd0) begin bad++; $display("FAIL full_empty got %0d want 0", level_o); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      retire_valid_i = 1'b1;
      ret_pc_i = 32'h3000 + 32'(i);
      step();
    end
    trc_ready_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    retire_valid_i = 1'b0;
    trc_ready_i = 1'b0;
    total++;
    if (level_o !== 5'd0 || trc_valid_o !== 1'b0 || drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_state got level=%0d v=%b drop=%0d ovf=%b want 0 0 0 0", level_o, trc_valid_o,
               drop_cnt_o, overflow_o);
    end
    retire_valid_i = 1'b1;
    ret_pc_i = 32'h77;
    step();
    retire_valid_i = 1'b0;
    total++;
    if (trc_valid_o !== 1'b1 || trc_seq_o !== 16'd0 || trc_pc_o !== 32'h77 || level_o !== 5'd1) begin
      bad++;
      $display("FAIL flush_next got v=%b seq=%0d pc=%h level=%0d want 1 0 77 1", trc_valid_o, trc_seq_o,
               trc_pc_o, level_o);
    end
  endtask

  task automatic test_back_to_back();
    do_flush();
    trc_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      retire_valid_i = 1'b1;
      ret_pc_i = 32'h4000 + 32'(i);
      step();
      total++;
      if (level_o !== 5'd1 || trc_seq_o !== 16'(i) || trc_pc_o !== 32'h4000 + 32'(i)) begin
        bad++;
        $display("FAIL b2b_%0d got level=%0d seq=%0d pc=%h want 1 %0d", i, level_o, trc_seq_o, trc_pc_o, i);
      end
    end
    retire_valid_i = 1'b0;
    step();
    trc_ready_i = 1'b0;
  endtask

  task automatic test_stability_saturation();
    do_flush();
    trc_ready_i = 1'b0;
    retire_valid_i = 1'b1;
    ret_pc_i = 32'hAAA0; ret_instr_i = 32'h1234_5678; ret_reg_addr_i = 5'd5;
    ret_reg_data_i = 32'hDEAD; ret_mem_addr_i = 32'h40; ret_mem_data_i = 32'h55; ret_mem_wrt_i = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      ret_pc_i = 32'hB000 + 32'(i); ret_instr_i = ~32'(i); ret_reg_addr_i = 5'(i);
      ret_reg_data_i = 32'(i); ret_mem_addr_i = 32'(i * 3); ret_mem_data_i = 32'(i * 7); ret_mem_wrt_i = 1'b0;
      step();
      total++;
      if (trc_valid_o !== 1'b1 || trc_seq_o !== 16'd0 || trc_gap_o !== 1'b0 || trc_pc_o !== 32'hAAA0 ||
          trc_instr_o !== 32'h1234_5678 || trc_reg_addr_o !== 5'd5 || trc_reg_data_o !== 32'hDEAD ||
          trc_mem_addr_o !== 32'h40 || trc_mem_data_o !== 32'h55 || trc_mem_wrt_o !== 1'b1) begin
        bad++;
        $display("FAIL stable_%0d got seq=%h pc=%h instr=%h rd=%0d want seq=0 pc=aaa0 instr=12345678 rd=5",
                 i, trc_seq_o, trc_pc_o, trc_instr_o, trc_reg_addr_o);
      end
    end
    total++;
    if (level_o !== 5'd11) begin bad++; $display("FAIL stable_level got %0d want 11", level_o); end
    for (int i = 0; i < 65540; i++) step();
    total++;
    if (drop_cnt_o !== 16'hFFFF || level_o !== 5'd16) begin
      bad++; $display("FAIL sat_reach got drop=%h level=%0d want ffff 16", drop_cnt_o, level_o);
    end
    for (int i = 0; i < 3; i++) step();
    retire_valid_i = 1'b0;
    total++;
    if (drop_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got %h want ffff", drop_cnt_o); end
    trc_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (trc_seq_o !== 16'(i)) begin
        bad++; $display("FAIL sat_drain_%0d got seq=%0d want %0d", i, trc_seq_o, i);
      end
      step();
    end
    trc_ready_i = 1'b0;
    retire_valid_i = 1'b1;
    step();
    retire_valid_i = 1'b0;
    total++;
    if (trc_seq_o !== 16'd18 || trc_gap_o !== 1'b1) begin
      bad++; $display("FAIL seq_wrap got seq=%0d gap=%b want 18 1", trc_seq_o, trc_gap_o);
    end
  endtask

  task automatic test_async_reset();
    trc_ready_i = 1'b1;
    retire_valid_i = 1'b1;
    ret_pc_i = 32'hC0DE;
    step();
    #2;
    rstn_i = 1'b0;
    #1;
    total++;
    if ({trc_valid_o, level_o, trc_seq_o, trc_gap_o, trc_pc_o, trc_instr_o, trc_reg_addr_o, trc_reg_data_o,
         trc_mem_addr_o, trc_mem_data_o, trc_mem_wrt_o, overflow_o, drop_cnt_o} !== '0) begin
      bad++;
      $display("FAIL async_reset got v=%b level=%0d seq=%h pc=%h ovf=%b drop=%h want all 0",
               trc_valid_o, level_o, trc_seq_o, trc_pc_o, overflow_o, drop_cnt_o);
    end
    retire_valid_i = 1'b0;
    trc_ready_i = 1'b0;
    step();
    total++;
    if (trc_valid_o !== 1'b0 || level_o !== 5'd0) begin
      bad++; $display("FAIL reset_hold got v=%b level=%0d want 0 0", trc_valid_o, level_o);
    end
  endtask

  initial begin
    test_reset();
    test_capture_drain();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_back_to_back();
    test_stability_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
